dm_port_arbiter: RTL and testbench

//  Parametrised N-channel arbiter for the single data-memory port; next-generation replacement for the

---
 rtl/dm_arb_pkg.sv | 28 ++
 rtl/rr_arb_pick.sv | 57 +++++
 rtl/dm_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// ----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory port arbiter:
//   arb_state_t : FSM state encoding (IDLE / ACCESS / RESP)
//   WAIT_CNT_W  : width of the wait-state counter
//   clog2()     : index width helper (never returns less than 1)
// ----------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int WAIT_CNT_W = 4;

    // Minimum width 1 so that a channel index always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// ----------------------------------------------------------------------------
// rr_arb_pick
// Combinational round-robin picker. Scans the unmasked requests starting at
// ptr_i and wrapping modulo NCH; the first set request wins.
// Ports:
//   req_i      [NCH-1:0]  request vector
//   mask_i     [NCH-1:0]  channels excluded from this pick
//   ptr_i      [IW-1:0]   channel with highest priority (must be < NCH)
//   gnt_oh_o   [NCH-1:0]  one-hot winner (zero when nothing eligible)
//   gnt_idx_o  [IW-1:0]   binary winner index
//   valid_o               an eligible request exists
// ----------------------------------------------------------------------------
module rr_arb_pick
    import dm_arb_pkg::*;
#(
    parameter int NCH = 3,
    localparam int IW = clog2(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [NCH-1:0] mask_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_oh_o,
    output logic [IW-1:0]  gnt_idx_o,
    output logic           valid_o
);

    logic [NCH-1:0] eff_req;
    logic [IW-1:0]  cand_idx [NCH];

    assign eff_req = req_i & ~mask_i;

    // cand_idx[k] is the channel examined at scan offset k: (ptr + k) mod NCH.
    // ptr < NCH and k < NCH, so a single conditional subtract is enough.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum          = {1'b0, ptr_i} + (IW+1)'(gi);
        assign cand_idx[gi] = (sum >= (IW+1)'(NCH)) ? IW'(sum - (IW+1)'(NCH))
                                                     : sum[IW-1:0];
    end

    // Walk from the lowest priority offset up so the smallest offset
    // with a request is the one left standing.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (eff_req[cand_idx[k]]) begin
                gnt_oh_o              = '0;
                gnt_oh_o[cand_idx[k]] = 1'b1;
                gnt_idx_o             = cand_idx[k];
                valid_o               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// ----------------------------------------------------------------------------
// dm_port_arbiter
// Round-robin arbiter sharing the single data-memory port between NCH
// requesters with WAIT_ST extra memory cycles per access.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   ch_req   [NCH]        level request per channel
//   ch_wrb   [NCH]        1=write, 0=read per channel
//   ch_add   [NCH*DMA]    packed addresses, channel i at [i*DMA_SIZE +: DMA_SIZE]
//   ch_wdt   [NCH*DMD]    packed write data, same packing
//   ch_gnt   [NCH]        one-hot pulse: request accepted, inputs latched
//   ch_done  [NCH]        one-hot pulse: access complete (arb_rdt valid next cycle for reads)
//   arb_rdt  [DMD]        registered read data, held until the next read completes
//   arb_busy              high in ACCESS and RESP
//   mem_cslt/mem_wrb/mem_add/mem_wdt  memory strobe, direction, address, write data
//   mem_rdt  [DMD]        memory read data, valid in the cycle after the last ACCESS cycle
// Grant and done are decoded from the current state so the grant lands in
// the arbitration cycle itself; this is what lets RESP hand the port
// straight to the next requester without an idle cycle.
// ----------------------------------------------------------------------------
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int DMA_SIZE = 16,
    parameter int DMD_SIZE = 16,
    parameter int WAIT_ST  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          ch_req,
    input  logic [NCH-1:0]          ch_wrb,
    input  logic [NCH*DMA_SIZE-1:0] ch_add,
    input  logic [NCH*DMD_SIZE-1:0] ch_wdt,
    output logic [NCH-1:0]          ch_gnt,
    output logic [NCH-1:0]          ch_done,
    output logic [DMD_SIZE-1:0]     arb_rdt,
    output logic                    arb_busy,
    output logic                    mem_cslt,
    output logic                    mem_wrb,
    output logic [DMA_SIZE-1:0]     mem_add,
    output logic [DMD_SIZE-1:0]     mem_wdt,
    input  logic [DMD_SIZE-1:0]     mem_rdt
);

    localparam int CH_W = clog2(NCH);

    arb_state_t              state_q;
    logic [CH_W-1:0]         rr_ptr_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q;
    logic [CH_W-1:0]         lat_ch_q;
    logic                    lat_wrb_q;
    logic [DMA_SIZE-1:0]     lat_add_q;
    logic [DMD_SIZE-1:0]     lat_wdt_q;
    logic [DMD_SIZE-1:0]     arb_rdt_q;

    logic [DMA_SIZE-1:0]     add_arr [NCH];
    logic [DMD_SIZE-1:0]     wdt_arr [NCH];
    logic [NCH-1:0]          lat_oh;
    logic [NCH-1:0]          pick_mask;
    logic [NCH-1:0]          pick_oh;
    logic [CH_W-1:0]         pick_idx;
    logic                    pick_valid;
    logic                    arb_ok;
    logic [CH_W-1:0]         next_ptr;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign add_arr[gi] = ch_add[gi*DMA_SIZE +: DMA_SIZE];
        assign wdt_arr[gi] = ch_wdt[gi*DMD_SIZE +: DMD_SIZE];
        assign lat_oh[gi]  = (lat_ch_q == CH_W'(gi));
    end

    // Arbitration happens in IDLE and RESP; in RESP the channel being
    // completed is masked so a requester that keeps req high goes last.
    assign arb_ok    = (state_q == IDLE) || (state_q == RESP);
    assign pick_mask = (state_q == RESP) ? lat_oh : '0;

    rr_arb_pick #(
        .NCH (NCH)
    ) u_pick (
        .req_i     (ch_req),
        .mask_i    (pick_mask),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    assign next_ptr = (pick_idx == CH_W'(NCH - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            wait_cnt_q <= '0;
            lat_ch_q   <= '0;
            lat_wrb_q  <= 1'b0;
            lat_add_q  <= '0;
            lat_wdt_q  <= '0;
            arb_rdt_q  <= '0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if ((state_q == RESP) && !lat_wrb_q) begin
                        arb_rdt_q <= mem_rdt;
                    end
                    if (pick_valid) begin
                        lat_ch_q   <= pick_idx;
                        lat_wrb_q  <= ch_wrb[pick_idx];
                        lat_add_q  <= add_arr[pick_idx];
                        lat_wdt_q  <= wdt_arr[pick_idx];
                        rr_ptr_q   <= next_ptr;
                        wait_cnt_q <= WAIT_CNT_W'(WAIT_ST);
                        state_q    <= ACCESS;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                ACCESS: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end else begin
                        state_q    <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // reset gates the grant so nothing is offered while the port is held in reset.
    assign ch_gnt   = (arb_ok && pick_valid && reset) ? pick_oh : '0;
    assign ch_done  = (state_q == RESP) ? lat_oh : '0;
    assign arb_rdt  = arb_rdt_q;
    assign arb_busy = (state_q == ACCESS) || (state_q == RESP);

    // Memory side is driven only while the strobe is active.
    assign mem_cslt = (state_q == ACCESS);
    assign mem_wrb  = mem_cslt & lat_wrb_q;
    assign mem_add  = mem_cslt ? lat_add_q : '0;
    assign mem_wdt  = mem_cslt ? lat_wdt_q : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dm_port_arbiter
// Directed bench for dm_port_arbiter: main instance with WAIT_ST=1 backed by
// a small memory model, plus WAIT_ST=0 and WAIT_ST=15 instances for the
// strobe-width cases.
// ----------------------------------------------------------------------------
module tb_dm_port_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  ch_req;
    logic [2:0]  req0;
    logic [2:0]  req15;
    logic [2:0]  ch_wrb;
    logic [47:0] ch_add;
    logic [47:0] ch_wdt;

    logic [2:0]  ch_gnt, ch_done;
    logic [15:0] arb_rdt, mem_add, mem_wdt;
    logic        arb_busy, mem_cslt, mem_wrb;
    logic [15:0] mem_rdt;

    logic [2:0]  g0, d0, g15, d15;
    logic [15:0] rdt0, add0, wdt0, rdt15, add15, wdt15;
    logic        busy0, cs0, wrb0, busy15, cs15, wrb15;
    logic [15:0] const_rdt;

    logic [15:0] mem [0:255];

    int checks;
    int errors;

    dm_port_arbiter #(.NCH(3), .DMA_SIZE(16), .DMD_SIZE(16), .WAIT_ST(1)) u_dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_wrb(ch_wrb),
        .ch_add(ch_add), .ch_wdt(ch_wdt), .ch_gnt(ch_gnt), .ch_done(ch_done),
        .arb_rdt(arb_rdt), .arb_busy(arb_busy), .mem_cslt(mem_cslt),
        .mem_wrb(mem_wrb), .mem_add(mem_add), .mem_wdt(mem_wdt), .mem_rdt(mem_rdt)
    );

    dm_port_arbiter #(.NCH(3), .DMA_SIZE(16), .DMD_SIZE(16), .WAIT_ST(0)) u_dut0 (
        .clk(clk), .reset(reset), .ch_req(req0), .ch_wrb(ch_wrb),
        .ch_add(ch_add), .ch_wdt(ch_wdt), .ch_gnt(g0), .ch_done(d0),
        .arb_rdt(rdt0), .arb_busy(busy0), .mem_cslt(cs0),
        .mem_wrb(wrb0), .mem_add(add0), .mem_wdt(wdt0), .mem_rdt(const_rdt)
    );

    dm_port_arbiter #(.NCH(3), .DMA_SIZE(16), .DMD_SIZE(16), .WAIT_ST(15)) u_dut15 (
        .clk(clk), .reset(reset), .ch_req(req15), .ch_wrb(ch_wrb),
        .ch_add(ch_add), .ch_wdt(ch_wdt), .ch_gnt(g15), .ch_done(d15),
        .arb_rdt(rdt15), .arb_busy(busy15), .mem_cslt(cs15),
        .mem_wrb(wrb15), .mem_add(add15), .mem_wdt(wdt15), .mem_rdt(const_rdt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read while selected.
    always @(posedge clk) begin
        if (mem_cslt) begin
            if (mem_wrb) mem[mem_add[7:0]] <= mem_wdt;
            mem_rdt <= mem[mem_add[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_ch(input int ch, input logic wrb, input logic [15:0] add,
                          input logic [15:0] wdt);
        ch_wrb[ch]         = wrb;
        ch_add[ch*16 +: 16] = add;
        ch_wdt[ch*16 +: 16] = wdt;
    endtask

    logic [2:0] exp_g;
    logic [2:0] exp_d;

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        ch_req    = 3'b111;
        req0      = 3'b000;
        req15     = 3'b000;
        ch_wrb    = '0;
        ch_add    = '0;
        ch_wdt    = '0;
        mem_rdt   = '0;
        const_rdt = 16'hA5A5;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h40] = 16'hBEEF;

        // Reset state (requests held high must not be granted)
        @(negedge clk); @(negedge clk); #1;
        chk("rst_gnt", ch_gnt, 3'b000);
        chk("rst_done", ch_done, 3'b000);
        chk("rst_busy", arb_busy, 1'b0);
        chk("rst_cslt", mem_cslt, 1'b0);
        chk("rst_rdt", arb_rdt, 16'h0000);
        @(negedge clk); reset = 1'b1; ch_req = 3'b000;

        // 1: single read by ch1
        @(negedge clk); set_ch(1, 1'b0, 16'h0040, 16'h0000); ch_req = 3'b010; #1;
        $display("t1 read ch1 @0040");
        chk("t1_gnt", ch_gnt, 3'b010);
        chk("t1_cslt_T", mem_cslt, 1'b0);
        @(negedge clk); ch_req = 3'b000; #1;
        chk("t1_cslt_T1", mem_cslt, 1'b1);
        chk("t1_add", mem_add, 16'h0040);
        chk("t1_wrb", mem_wrb, 1'b0);
        chk("t1_gnt_off", ch_gnt, 3'b000);
        @(negedge clk); #1;
        chk("t1_cslt_T2", mem_cslt, 1'b1);
        chk("t1_nodone", ch_done, 3'b000);
        @(negedge clk); #1;
        chk("t1_cslt_T3", mem_cslt, 1'b0);
        chk("t1_done", ch_done, 3'b010);
        chk("t1_busy_resp", arb_busy, 1'b1);
        @(negedge clk); #1;
        chk("t1_rdt", arb_rdt, 16'hBEEF);
        chk("t1_done_off", ch_done, 3'b000);
        chk("t1_idle", arb_busy, 1'b0);

        // 2: ch0 write 0x1234 @0010 then read back
        @(negedge clk); set_ch(0, 1'b1, 16'h0010, 16'h1234); ch_req = 3'b001; #1;
        $display("t2 write ch0 @0010 = 1234, read back");
        chk("t2_gnt_w", ch_gnt, 3'b001);
        @(negedge clk); ch_req = 3'b000; #1;
        chk("t2_wrb", mem_wrb, 1'b1);
        chk("t2_wdt", mem_wdt, 16'h1234);
        chk("t2_add", mem_add, 16'h0010);
        @(negedge clk); #1;
        chk("t2_wrb2", mem_wrb, 1'b1);
        // Done cycle: ch0 re-requests (read); it is masked in RESP.
        @(negedge clk); set_ch(0, 1'b0, 16'h0010, 16'h0000); ch_req = 3'b001; #1;
        chk("t2_done_w", ch_done, 3'b001);
        chk("t2_masked", ch_gnt, 3'b000);
        @(negedge clk); #1;
        chk("t2_rdt_hold", arb_rdt, 16'hBEEF);
        chk("t2_gnt_r", ch_gnt, 3'b001);
        @(negedge clk); ch_req = 3'b000; #1;
        chk("t2_rd_wrb", mem_wrb, 1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t2_done_r", ch_done, 3'b001);
        @(negedge clk); #1;
        chk("t2_rdt", arb_rdt, 16'h1234);

        // 3: all channels from reset, held -> 0,1,2,0,1,2 back-to-back
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        set_ch(0, 1'b0, 16'h0001, 16'h0);
        set_ch(1, 1'b0, 16'h0002, 16'h0);
        set_ch(2, 1'b0, 16'h0003, 16'h0);
        @(negedge clk); ch_req = 3'b111; #1;
        for (int i = 0; i < 6; i++) begin
            exp_g = 3'b001 << (i % 3);
            exp_d = (i == 0) ? 3'b000 : (3'b001 << ((i + 2) % 3));
            $display("t3 round %0d expect gnt=%b done=%b", i, exp_g, exp_d);
            chk("t3_gnt", ch_gnt, exp_g);
            chk("t3_done", ch_done, exp_d);
            for (int k = 0; k < 2; k++) begin
                @(negedge clk); if (i == 5) ch_req = 3'b000; #1;
                chk("t3_cslt", mem_cslt, 1'b1);
                chk("t3_gnt_off", ch_gnt, 3'b000);
            end
            @(negedge clk); #1;
        end
        chk("t3_last_done", ch_done, 3'b100);
        chk("t3_last_gnt", ch_gnt, 3'b000);

        // 4: rr_ptr wrapped to 0 -> ch0 before ch2; lone ch2 served again
        @(negedge clk); ch_req = 3'b101; #1;
        $display("t4 wrap: req=101");
        chk("t4_gnt0", ch_gnt, 3'b001);
        @(negedge clk); ch_req = 3'b100; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t4_done0", ch_done, 3'b001);
        chk("t4_gnt2", ch_gnt, 3'b100);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t4_done2", ch_done, 3'b100);
        chk("t4_mask2", ch_gnt, 3'b000);
        @(negedge clk); #1;
        chk("t4_gnt2_again", ch_gnt, 3'b100);
        @(negedge clk); ch_req = 3'b000; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t4_done2_again", ch_done, 3'b100);

        // 5: reset in the first ACCESS cycle
        @(negedge clk); ch_req = 3'b010; #1;
        $display("t5 reset mid-access");
        chk("t5_gnt", ch_gnt, 3'b010);
        @(negedge clk); ch_req = 3'b000; #1;
        chk("t5_cslt", mem_cslt, 1'b1);
        reset = 1'b0; #1;
        chk("t5_cslt_drop", mem_cslt, 1'b0);
        chk("t5_busy_drop", arb_busy, 1'b0);
        @(negedge clk); reset = 1'b1; #1;
        chk("t5_nodone_a", ch_done, 3'b000);
        @(negedge clk); #1;
        chk("t5_nodone_b", ch_done, 3'b000);
        chk("t5_idle", arb_busy, 1'b0);
        @(negedge clk); ch_req = 3'b110; #1;
        chk("t5_ptr0_gnt", ch_gnt, 3'b010);
        @(negedge clk); ch_req = 3'b000; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t5_done", ch_done, 3'b010);

        // 6a: WAIT_ST=0 -> one strobe cycle, req change during ACCESS ignored
        @(negedge clk); req0 = 3'b001; #1;
        $display("t6 WAIT_ST=0");
        chk("t6a_gnt", g0, 3'b001);
        @(negedge clk); req0 = 3'b010; #1;
        chk("t6a_cslt", cs0, 1'b1);
        chk("t6a_ignored", g0, 3'b000);
        @(negedge clk); req0 = 3'b000; #1;
        chk("t6a_cslt_end", cs0, 1'b0);
        chk("t6a_done", d0, 3'b001);
        @(negedge clk); #1;
        chk("t6a_idle", busy0, 1'b0);

        // 6b: WAIT_ST=15 -> sixteen strobe cycles with toggling req
        @(negedge clk); req15 = 3'b001; #1;
        $display("t6 WAIT_ST=15");
        chk("t6b_gnt", g15, 3'b001);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); req15 = (k % 2 == 1) ? 3'b110 : 3'b000; #1;
            chk("t6b_cslt", cs15, 1'b1);
            chk("t6b_ignored", g15, 3'b000);
            chk("t6b_nodone", d15, 3'b000);
        end
        @(negedge clk); req15 = 3'b000; #1;
        chk("t6b_cslt_end", cs15, 1'b0);
        chk("t6b_done", d15, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
